banco_ctrl: RTL
===============

# banco_ctrl

Access controller for the register bank (`BancoRegistro`-style storage: 2^BIT_ADDR words of BIT_DATO bits, synchronous write, combinational read). It sits between the bank and two independent requesters, for example the switch/button front-end and a test-pattern engine. It arbitrates round-robin between them, sequences single-word reads and writes over a req/gnt handshake, and performs a zero-fill sweep of the whole bank after reset or on command. The bank itself is unchanged; `banco_ctrl` drives its write port and one read port.

## Interface
- BIT_ADDR, 2: address width; NREG = 2**BIT_ADDR words.
- BIT_DATO, 4: data word width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_a  in  1  requester A access request; held high until gnt_a seen.
- we_a  in  1  A: 1 = write, 0 = read; stable while req_a high.
- addr_a  in  BIT_ADDR  A target address.
- dat_a  in  BIT_DATO  A write data.
- gnt_a  out  1  one-cycle completion pulse to A.
- rdat_a  out  BIT_DATO  A read data; valid when gnt_a=1, held until next A read completes.
- req_b, we_b, addr_b, dat_b, gnt_b, rdat_b: identical set for requester B.
- clr_start  in  1  request a zero-fill sweep; sampled only in IDLE.
- busy  out  1  high in CLEAR state.
- bank_we  out  1  bank write enable.
- bank_addrW  out  BIT_ADDR  bank write address.
- bank_datW  out  BIT_DATO  bank write data.
- bank_addrR  out  BIT_ADDR  bank read address.
- bank_datR  in  BIT_DATO  bank combinational read data.

## Operation
- FSM states: CLEAR, IDLE, SERVE, DONE. Reset state is CLEAR.
- CLEAR:
  - Uses a sweep counter clr_ptr, starting at 0.
  - Each cycle drives bank_we=1, bank_addrW=clr_ptr, bank_datW=0, then increments clr_ptr.
  - After the write of address NREG-1 the FSM goes to IDLE and clr_ptr returns to 0.
- IDLE, evaluated in priority order:
  - clr_start=1 → CLEAR. Any pending requests wait.
  - Otherwise one or more reqs high → choose a winner, latch its we/addr/dat into op registers, go to SERVE.
  - Otherwise stay in IDLE.
- Arbitration:
  - If only one req is high, it wins.
  - If both are high, the winner is the requester that was not served last. The last-served pointer updates on every grant.
  - After reset the pointer = B, so A wins the first tie.
- SERVE (one cycle), driven from the latched op registers:
  - Write op: bank_we=1, bank_addrW=op_addr, bank_datW=op_dat.
  - Read op: bank_we=0, bank_addrR=op_addr. At the edge ending SERVE, bank_datR is captured into the winner's rdat register.
  - Next state is DONE.
- DONE (one cycle):
  - The winner's gnt is high. All bank_we are 0.
  - Next state is IDLE.
  - The requester drops or changes req on the edge ending DONE. Because requests are not sampled in DONE, a stale req is never double-served.
- bank_addrR:
  - In SERVE it equals op_addr.
  - Elsewhere it holds its last value (0 after reset).
  - The register file read port is otherwise unused by this block.
- bank_we is 0 in IDLE and DONE. Write data and address are don't-care when bank_we=0, but are held stable.
- clr_start outside IDLE is ignored, not queued.
- Reset asserted at any time, including mid-sweep or in SERVE/DONE:
  - Outputs return immediately to their reset values.
  - An in-flight op is discarded without a grant.
  - A full sweep restarts on release.

## Timing
- Reset values:
  - gnt_a = gnt_b = 0.
  - rdat_a = rdat_b = 0.
  - bank_we = 0, bank_addrW = 0, bank_datW = 0, bank_addrR = 0.
  - busy = 1 (the state is CLEAR).
  - The sweep begins on the first clk edge after rst deasserts.
- Sweep takes NREG cycles with busy=1, then IDLE.
- Request latency: req sampled high in IDLE at edge N → SERVE in cycle N+1 → gnt pulse in cycle N+2.
- Throughput: one access per 3 cycles (IDLE, SERVE, DONE).
- Write is visible in the bank from the edge ending SERVE. A read by the other requester granted next returns the new value.
- All outputs come from registers or from state-decoded registered ops, with no combinational path from req inputs.

## Test plan
- Reset then release, NREG=4:
  - busy=1 for exactly 4 cycles.
  - bank_we=1 with bank_addrW = 0,1,2,3 and bank_datW=0.
  - Then busy=0 and gnt_a = gnt_b = 0.
- A writes 0x9 to addr 2, then A reads addr 2:
  - gnt_a arrives 2 cycles after each req.
  - rdat_a = 0x9 in the gnt_a cycle.
- req_a and req_b raised in the same cycle (A write 0x5 to addr 1, B read addr 1):
  - A is granted first, B second.
  - rdat_b = 0x5.
  - On the next simultaneous pair, B wins.
- clr_start and req_a high together in IDLE after addr 3 was written with 0xF:
  - The sweep runs first and busy=1 for 4 cycles.
  - A's subsequent read of addr 3 returns 0x0.
- clr_start pulsed while in SERVE: ignored, so no sweep and busy stays 0.
- rst asserted during SERVE of a write of 0x7 to addr 0:
  - No gnt_a is issued.
  - Outputs are at reset values.
  - After release the sweep reruns and a read of addr 0 returns 0x0.

Source files
------------

// File: rtl/banco_ctrl_if.sv
// Requester, sweep-control and register-bank signals of banco_ctrl.
// The controller binds to the slave modport; requesters and the bank side use the master modport.
interface banco_ctrl_if #(
  parameter int BIT_ADDR = 2,
  parameter int BIT_DATO = 4
);
  logic                req_a;
  logic                we_a;
  logic [BIT_ADDR-1:0] addr_a;
  logic [BIT_DATO-1:0] dat_a;
  logic                gnt_a;
  logic [BIT_DATO-1:0] rdat_a;

  logic                req_b;
  logic                we_b;
  logic [BIT_ADDR-1:0] addr_b;
  logic [BIT_DATO-1:0] dat_b;
  logic                gnt_b;
  logic [BIT_DATO-1:0] rdat_b;

  logic                clr_start;
  logic                busy;

  logic                bank_we;
  logic [BIT_ADDR-1:0] bank_addrW;
  logic [BIT_DATO-1:0] bank_datW;
  logic [BIT_ADDR-1:0] bank_addrR;
  logic [BIT_DATO-1:0] bank_datR;

  modport master (
    output req_a, we_a, addr_a, dat_a, req_b, we_b, addr_b, dat_b, clr_start, bank_datR,
    input  gnt_a, rdat_a, gnt_b, rdat_b, busy, bank_we, bank_addrW, bank_datW, bank_addrR
  );

  modport slave (
    input  req_a, we_a, addr_a, dat_a, req_b, we_b, addr_b, dat_b, clr_start, bank_datR,
    output gnt_a, rdat_a, gnt_b, rdat_b, busy, bank_we, bank_addrW, bank_datW, bank_addrR
  );
endinterface

// File: rtl/banco_ctrl.sv
// Round-robin access controller for a register bank with zero-fill sweep after reset or on command.
// Access latency: req sampled in IDLE -> SERVE -> one-cycle gnt in DONE; sweep takes 2**BIT_ADDR cycles.
module banco_ctrl #(
  parameter int BIT_ADDR = 2,
  parameter int BIT_DATO = 4
) (
  input logic        clk,
  input logic        rst,
  banco_ctrl_if.slave bus
);
  localparam int NREG = 2 ** BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] LAST_ADDR = BIT_ADDR'(NREG - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SERVE, S_DONE} state_t;

  state_t              r_state, w_nxt;
  logic                r_live;
  logic [BIT_ADDR-1:0] r_clr_ptr, w_ptr_nxt;
  logic                r_last_b;
  logic                r_op_sel_b, r_op_we;
  logic                r_gnt_a, r_gnt_b;
  logic [BIT_DATO-1:0] r_rdat_a, r_rdat_b;
  logic                r_bank_we;
  logic [BIT_ADDR-1:0] r_bank_addrW, r_bank_addrR;
  logic [BIT_DATO-1:0] r_bank_datW;

  logic                w_sel_b, w_win_we;
  logic [BIT_ADDR-1:0] w_win_addr;
  logic [BIT_DATO-1:0] w_win_dat;

  // B wins when alone, or on a tie when A was the last one served.
  always_comb begin
    w_sel_b    = bus.req_b & (~bus.req_a | ~r_last_b);
    w_win_we   = w_sel_b ? bus.we_b   : bus.we_a;
    w_win_addr = w_sel_b ? bus.addr_b : bus.addr_a;
    w_win_dat  = w_sel_b ? bus.dat_b  : bus.dat_a;
  end

  always_comb begin
    w_nxt     = r_state;
    w_ptr_nxt = r_clr_ptr;
    case (r_state)
      S_CLEAR: begin
        // r_live holds the sweep off for the reset cycle itself.
        if (r_live) begin
          w_ptr_nxt = r_clr_ptr + BIT_ADDR'(1);
          if (r_clr_ptr == LAST_ADDR) w_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (bus.clr_start)              w_nxt = S_CLEAR;
        else if (bus.req_a | bus.req_b) w_nxt = S_SERVE;
      end
      S_SERVE: w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_CLEAR;
      r_live       <= 1'b0;
      r_clr_ptr    <= '0;
      r_last_b     <= 1'b1;
      r_op_sel_b   <= 1'b0;
      r_op_we      <= 1'b0;
      r_gnt_a      <= 1'b0;
      r_gnt_b      <= 1'b0;
      r_rdat_a     <= '0;
      r_rdat_b     <= '0;
      r_bank_we    <= 1'b0;
      r_bank_addrW <= '0;
      r_bank_datW  <= '0;
      r_bank_addrR <= '0;
    end else begin
      r_state   <= w_nxt;
      r_live    <= 1'b1;
      r_clr_ptr <= w_ptr_nxt;
      r_gnt_a   <= (r_state == S_SERVE) && !r_op_sel_b;
      r_gnt_b   <= (r_state == S_SERVE) &&  r_op_sel_b;
      if (r_state == S_SERVE && !r_op_we) begin
        if (r_op_sel_b) r_rdat_b <= bus.bank_datR;
        else            r_rdat_a <= bus.bank_datR;
      end
      // Bank port registers are loaded one edge ahead of the cycle that uses them.
      r_bank_we <= 1'b0;
      if (w_nxt == S_CLEAR) begin
        r_bank_we    <= 1'b1;
        r_bank_addrW <= w_ptr_nxt;
        r_bank_datW  <= '0;
      end else if (w_nxt == S_SERVE) begin
        r_op_sel_b   <= w_sel_b;
        r_op_we      <= w_win_we;
        r_last_b     <= w_sel_b;
        r_bank_addrR <= w_win_addr;
        if (w_win_we) begin
          r_bank_we    <= 1'b1;
          r_bank_addrW <= w_win_addr;
          r_bank_datW  <= w_win_dat;
        end
      end
    end
  end

  assign bus.busy       = (r_state == S_CLEAR);
  assign bus.gnt_a      = r_gnt_a;
  assign bus.gnt_b      = r_gnt_b;
  assign bus.rdat_a     = r_rdat_a;
  assign bus.rdat_b     = r_rdat_b;
  assign bus.bank_we    = r_bank_we;
  assign bus.bank_addrW = r_bank_addrW;
  assign bus.bank_datW  = r_bank_datW;
  assign bus.bank_addrR = r_bank_addrR;
endmodule
